// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the digit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Counter width for n digit steps; a single-step operation still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its MSB
// so the caller can derive signed overflow on the last digit.
module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end

    assign cout_o = c[DIGIT];
    assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: N = WIDTH/DIGIT cycles per operation,
// results and flags only update on the completion edge.
//   state | meaning
//   IDLE  | waiting for start; res/flags hold the last completed result
//   RUN   | one DIGIT slice summed per clock, LSB slice first
module seq_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((DIGIT < 1) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $fatal(1, "seq_addsub: DIGIT must be >= 1 and divide WIDTH evenly");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout;
    logic                   dcmsb;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a_i    (opa_q[DIGIT-1:0]),
        .b_i    (opb_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (dsum),
        .cout_o (dcout),
        .cmsb_o (dcmsb)
    );

    // New slice enters at the MSB end; after N steps the LSB slice has reached bit 0.
    assign acc_cat   = {dsum, acc_q};
    assign acc_shift = acc_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = dcout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = acc_shift;
                    cout_d  = dcout;
                    ovf_d   = dcout ^ dcmsb;
                    zero_d  = (acc_shift == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign res  = res_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: main 32/8 instance plus 32/1, 32/32 and 16/4 variants.
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        reset, start, sub;
    logic [31:0] a, b;

    logic        busy8, done8, cout8, ovf8, zero8;
    logic [31:0] res8;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [31:0] res1;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] res32;
    logic        busy16, done16, cout16, ovf16, zero16;
    logic [15:0] res16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r32;
        logic [2:0]  f32;   // {cout, ovf, zero}
        logic [15:0] r16;
        logic [2:0]  f16;
    } vec_t;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy8), .done(done8), .res(res8), .cout(cout8), .ovf(ovf8), .zero(zero8));

    seq_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .res(res1), .cout(cout1), .ovf(ovf1), .zero(zero1));

    seq_addsub #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy32), .done(done32), .res(res32), .cout(cout32), .ovf(ovf32), .zero(zero32));

    seq_addsub #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .res(res16), .cout(cout16), .ovf(ovf16), .zero(zero16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
        sub   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!done8 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++;
        if ({busy8, done8, res8, cout8, ovf8, zero8} !== 36'h0) begin
            errors++;
            $display("FAIL reset_main: got busy=%b done=%b res=%h c/o/z=%b%b%b, want all 0",
                     busy8, done8, res8, cout8, ovf8, zero8);
        end
        checks++;
        if ({busy1, done1, res1, busy32, done32, res32, busy16, done16, res16} !== 86'h0) begin
            errors++;
            $display("FAIL reset_variants: got res1=%h res32=%h res16=%h busy=%b%b%b, want all 0",
                     res1, res32, res16, busy1, busy32, busy16);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    task automatic test_sub_cases();
        vec_t v[6];
        int   lat;
        v[0] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 3'b000, 16'h0, 3'b000};
        v[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b101, 16'h0, 3'b000};
        v[2] = '{1'b1, 32'h0003FFFF, 32'hFFFFFFFF, 32'h00040000, 3'b000, 16'h0, 3'b000};
        v[3] = '{1'b1, 32'h0003FFFF, 32'h00000000, 32'h0003FFFF, 3'b100, 16'h0, 3'b000};
        v[4] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b010, 16'h0, 3'b000};
        v[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b110, 16'h0, 3'b000};
        for (int i = 0; i < 6; i++) begin
            launch(v[i].s, v[i].x, v[i].y);
            wait_done8(lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles, want 4", i, lat);
            end
            checks++;
            if (res8 !== v[i].r32) begin
                errors++;
                $display("FAIL res_%0d: got %h, want %h", i, res8, v[i].r32);
            end
            checks++;
            if ({cout8, ovf8, zero8} !== v[i].f32) begin
                errors++;
                $display("FAIL flags_%0d: got c/o/z=%b, want %b", i, {cout8, ovf8, zero8}, v[i].f32);
            end
            tick();
            checks++;
            if (done8 !== 1'b0 || res8 !== v[i].r32) begin
                errors++;
                $display("FAIL done_pulse_%0d: got done=%b res=%h, want done=0 res=%h",
                         i, done8, res8, v[i].r32);
            end
        end
    endtask

    task automatic test_ignore_start();
        launch(1'b0, 32'h00000001, 32'h00000002);
        sub = 1'b1; a = 32'h00000100; b = 32'h00000200; start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        checks++;
        if ({busy8, done8} !== 2'b10) begin
            errors++;
            $display("FAIL busy_during_run: got busy=%b done=%b, want 1 0", busy8, done8);
        end
        tick();
        checks++;
        if (done8 !== 1'b1 || res8 !== 32'h00000003 || {cout8, ovf8, zero8} !== 3'b000) begin
            errors++;
            $display("FAIL ignored_start: got done=%b res=%h c/o/z=%b, want 1 00000003 000",
                     done8, res8, {cout8, ovf8, zero8});
        end
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL no_restart: got busy=%b, want 0", busy8);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic held;
        launch(1'b0, 32'h00000010, 32'h00000020);
        wait_done8(lat);
        checks++;
        if (lat !== 4 || res8 !== 32'h00000030) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d res=%h, want 4 00000030", lat, res8);
        end
        launch(1'b0, 32'h00001000, 32'h00000234);
        checks++;
        if ({busy8, done8} !== 2'b10 || res8 !== 32'h00000030) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b res=%h, want 1 0 00000030",
                     busy8, done8, res8);
        end
        held = 1'b1;
        lat  = 0;
        while (!done8 && lat < 64) begin
            if (res8 !== 32'h00000030) held = 1'b0;
            tick();
            lat++;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: res changed before completion, want held at 00000030");
        end
        checks++;
        if (lat !== 4 || res8 !== 32'h00001234) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d res=%h, want 4 00001234", lat, res8);
        end
    endtask

    task automatic test_reset_midrun();
        int   lat;
        logic seen;
        tick();
        launch(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done8(lat);
        launch(1'b0, 32'h00000005, 32'h00000006);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy8, done8, res8, cout8, ovf8, zero8} !== 36'h0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b res=%h c/o/z=%b%b%b, want all 0",
                     busy8, done8, res8, cout8, ovf8, zero8);
        end
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (done8) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: got a done pulse after reset, want none");
        end
        launch(1'b0, 32'h00000005, 32'h00000006);
        wait_done8(lat);
        checks++;
        if (lat !== 4 || res8 !== 32'h0000000B || {cout8, ovf8, zero8} !== 3'b000) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d res=%h c/o/z=%b, want 4 0000000b 000",
                     lat, res8, {cout8, ovf8, zero8});
        end
    endtask

    task automatic test_widths();
        vec_t v[6];
        int   l1, l32, l16, n;
        v[0] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 3'b000, 16'h0001, 3'b000};
        v[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b101, 16'h0000, 3'b101};
        v[2] = '{1'b1, 32'h0003FFFF, 32'hFFFFFFFF, 32'h00040000, 3'b000, 16'h0000, 3'b101};
        v[3] = '{1'b1, 32'h0003FFFF, 32'h00000000, 32'h0003FFFF, 3'b100, 16'hFFFF, 3'b100};
        v[4] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b010, 16'h0000, 3'b101};
        v[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b110, 16'hFFFF, 3'b000};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            launch(v[i].s, v[i].x, v[i].y);
            l1 = -1; l32 = -1; l16 = -1;
            for (n = 1; n <= 40; n++) begin
                tick();
                if (done1  && l1  < 0) l1  = n;
                if (done32 && l32 < 0) l32 = n;
                if (done16 && l16 < 0) l16 = n;
            end
            checks++;
            if (l1 !== 32 || l32 !== 1 || l16 !== 4) begin
                errors++;
                $display("FAIL var_latency_%0d: got d1=%0d d32=%0d w16=%0d, want 32 1 4",
                         i, l1, l32, l16);
            end
            checks++;
            if (res1 !== v[i].r32 || {cout1, ovf1, zero1} !== v[i].f32) begin
                errors++;
                $display("FAIL d1_%0d: got res=%h c/o/z=%b, want %h %b",
                         i, res1, {cout1, ovf1, zero1}, v[i].r32, v[i].f32);
            end
            checks++;
            if (res32 !== v[i].r32 || {cout32, ovf32, zero32} !== v[i].f32) begin
                errors++;
                $display("FAIL d32_%0d: got res=%h c/o/z=%b, want %h %b",
                         i, res32, {cout32, ovf32, zero32}, v[i].r32, v[i].f32);
            end
            checks++;
            if (res16 !== v[i].r16 || {cout16, ovf16, zero16} !== v[i].f16) begin
                errors++;
                $display("FAIL w16_%0d: got res=%h c/o/z=%b, want %h %b",
                         i, res16, {cout16, ovf16, zero16}, v[i].r16, v[i].f16);
            end
            checks++;
            if ({busy1, busy32, busy16} !== 3'b000) begin
                errors++;
                $display("FAIL var_idle_%0d: got busy d1/d32/w16=%b, want 000",
                         i, {busy1, busy32, busy16});
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_cases();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_widths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
